spi_master_ctrl: RTL and testbench
==================================

# spi_master_ctrl

Parametrised SPI master engine that serialises one `DATA_W`-bit word per transfer. It supports all four CPOL/CPHA modes, a runtime clock divider and `NUM_CS` one-hot-free chip selects. It sits between the instruction-decoding core and the external SPI pins, and replaces direct pin handling in the core with a start/busy/done handshake. Full duplex: MOSI shifts out `tx_data` while MISO is captured into `rx_data`.

## Interface
- `DATA_W`, 8: bits per transfer, ≥2.
- `NUM_CS`, 2: number of chip-select lines, ≥1.
- `DIV_W`, 8: width of the clock-divider input.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clock` in 1: sole clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: request a transfer; sampled only when idle.
- `cs_sel` in $clog2(NUM_CS) (min 1): target chip select.
- `cpol` in 1: SCLK idle level.
- `cpha` in 1: 0 = sample on leading edge, 1 = sample on trailing edge.
- `clk_div` in DIV_W: SCLK half-period = `clk_div`+1 clocks.
- `tx_data` in DATA_W: word to send, MSB first.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle pulse at end of transfer.
- `err` out 1: one-cycle pulse when `start` is rejected.
- `rx_data` out DATA_W: last received word; holds until the next `done`.
- `sclk` out 1: serial clock.
- `mosi` out 1: serial data out.
- `miso` in 1: serial data in.
- `nss` out NUM_CS: active-low chip selects.

## Operation
- Reset values:
  - `sclk`=0, `mosi`=0, `nss`=all 1, `busy`=0, `done`=0, `err`=0, `rx_data`=0.
  - Shift and counters are cleared; FSM goes to IDLE.
- IDLE:
  - `start`=1 and `cs_sel`<NUM_CS: latch `cpol`, `cpha`, `clk_div`, `cs_sel` and `tx_data`, then go to SETUP.
  - `start`=1 and `cs_sel`≥NUM_CS: pulse `err` next cycle and stay in IDLE.
  - In IDLE, `sclk` = latched `cpol` (0 after reset).
- SETUP:
  - Drive `nss[cs]`=0 and `mosi`=tx MSB.
  - Lasts one half-period, then go to SHIFT.
- SHIFT: 2·DATA_W half-periods. `sclk` toggles at the end of each half-period.
  - Odd toggles are leading edges; even toggles are trailing edges.
  - CPHA=0: sample `miso` on leading edges; shift `mosi` to the next bit on trailing edges (no shift after the last bit).
  - CPHA=1: shift `mosi` on leading edges (first leading edge presents the MSB); sample on trailing edges.
  - After 2·DATA_W toggles `sclk` is back at `cpol`; go to HOLD.
- HOLD:
  - `nss[cs]` stays low for one half-period.
  - Then: `nss` all 1, `rx_data` updated, `done`=1 and `busy`=0 in the same cycle; return to IDLE.
- `start` while `busy`=1 is ignored; no `err` pulse.
- Pin changes, sample points, latches and pulse outputs are all registered: `sclk`, `mosi` and `nss` transitions, `miso` sampling, and the `done` and `err` pulses.
- Reset mid-transfer: `nss` deasserts and `sclk` returns to 0 on the next edge; no `done` pulse; `rx_data` is cleared.

## Timing
- `start` accepted at cycle 0:
  - `busy`=1 and `nss` low from cycle 1.
  - `done` at cycle 1 + (2·DATA_W+2)·(`clk_div`+1).
- Examples with DATA_W=8: `clk_div`=0 → `done` at cycle 19; `clk_div`=3 → cycle 73.
- A new `start` may be asserted in the `done` cycle; it is accepted, since the FSM is IDLE in that cycle.
- `clk_div` wider than needed is not a concern: it is latched, so input changes mid-transfer have no effect.

## Structure
- Package `spi_pkg`:
  - `spi_state_t` enum (IDLE, SETUP, SHIFT, HOLD).
  - `spi_mode_t` packed struct {cpol, cpha}.
  - Constant `SPI_MODE0..3`.
- Sub-module `spi_clk_gen`: half-period down-counter that emits a one-cycle `tick` every `clk_div`+1 clocks while enabled, and reloads on enable.
- Top level: FSM, edge counter ($clog2(2·DATA_W+1) bits), TX and RX shift registers.

## Test plan
- Mode 0, `clk_div`=0, `tx_data`=0xA5, `mosi` looped to `miso` → `rx_data`=0xA5, `done` at cycle 19, `nss[0]` low cycles 1–18.
- Mode 3, `clk_div`=1, slave model drives 0x3C, `tx_data`=0x81 → `rx_data`=0x3C; MOSI bits seen 1,0,0,0,0,0,0,1; `sclk` idle high before and after.
- `clk_div`=3, mode 1 → `done` exactly at cycle 73; `sclk` high/low runs of 4 clocks.
- `start` pulsed at cycle 5 of an active transfer → ignored; exactly one `done`, no `err`.
- `cs_sel`=2 with NUM_CS=2 → `err` pulse at cycle 1, `nss` stays all 1, `busy` stays 0.
- `reset` asserted at cycle 8 mid-transfer → next cycle `nss`=all 1, `sclk`=0, `busy`=0, `rx_data`=0, no `done`.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI master types and mode constants
package spi_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} spi_state_t;
  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;
  localparam spi_mode_t SPI_MODE0 = 2'b00;
  localparam spi_mode_t SPI_MODE1 = 2'b01;
  localparam spi_mode_t SPI_MODE2 = 2'b10;
  localparam spi_mode_t SPI_MODE3 = 2'b11;
endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: half-period down-counter, one-cycle tick every div+1 clocks while enabled
module spi_clk_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;
  assign tick = en && cnt == '0;
  always_ff @(posedge clock)
    cnt <= reset ? '0 : (!en || tick) ? div : cnt - 1'b1;
endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: full-duplex SPI master, all CPOL/CPHA modes, runtime divider, start/busy/done handshake
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 2,
  parameter int DIV_W  = 8,
  localparam int CS_W  = NUM_CS > 1 ? $clog2(NUM_CS) : 1,
  localparam int EC_W  = $clog2(2 * DATA_W + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] nss
);
  spi_state_t        state, state_n;
  spi_mode_t         mode_q;
  logic [DIV_W-1:0]  div_q;
  logic [DATA_W-1:0] tx_sr, rx_sr;
  logic [EC_W-1:0]   ecnt;
  logic              tick, accept, lead, last, cs_ok;
  assign cs_ok  = int'(cs_sel) < NUM_CS;
  assign accept = state == IDLE && start && cs_ok;
  assign busy   = state != IDLE;
  assign lead   = ~ecnt[0];
  assign last   = ecnt == EC_W'(2 * DATA_W - 1);
  // while idle the counter preloads from the live divider so SETUP starts with a full half-period
  spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
    .clock (clock),
    .reset (reset),
    .en    (busy),
    .div   (busy ? div_q : clk_div),
    .tick  (tick)
  );
  always_ff @(posedge clock)
    state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    if (accept) state_n = SETUP;
    else if (tick) state_n = state == SETUP ? SHIFT : state == HOLD ? IDLE : last ? HOLD : SHIFT;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q  <= SPI_MODE0;
      div_q   <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      ecnt    <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      nss     <= '1;
      done    <= 1'b0;
      err     <= 1'b0;
      rx_data <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state == IDLE) begin
        sclk <= accept ? cpol : mode_q.cpol;
        err  <= start && !cs_ok;
        if (accept) begin
          mode_q <= {cpol, cpha};
          div_q  <= clk_div;
          // CPHA=1 re-presents the MSB on the first leading edge, so keep it in the shifter
          tx_sr  <= cpha ? tx_data : tx_data << 1;
          mosi   <= tx_data[DATA_W-1];
          rx_sr  <= '0;
          ecnt   <= '0;
          nss    <= ~(NUM_CS'(1) << cs_sel);
        end
      end else if (tick && state == SHIFT) begin
        sclk <= ~sclk;
        ecnt <= ecnt + 1'b1;
        if (lead ^ mode_q.cpha) rx_sr <= {rx_sr[DATA_W-2:0], miso};
        if (mode_q.cpha ? lead : (!lead && !last)) begin
          mosi  <= tx_sr[DATA_W-1];
          tx_sr <= tx_sr << 1;
        end
      end else if (tick && state == HOLD) begin
        nss     <= '1;
        rx_data <= rx_sr;
        done    <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: table-driven transfers plus reject/ignore/reset sequences
module tb_spi_master_ctrl;
  import spi_pkg::*;
  logic clock = 0, reset = 1, start = 0, cpol = 0, cpha = 0;
  logic [1:0] cs_sel = 0;
  logic [7:0] clk_div = 0, tx_data = 0, rx_data;
  logic busy, done, err, sclk, mosi, miso;
  logic [2:0] nss;
  logic slave_en = 0, slave_bit = 0;
  logic [7:0] s_sr = 0, mosi_seen = 0;
  int total = 0, bad = 0, done_cnt = 0, err_cnt = 0;

  spi_master_ctrl #(.DATA_W(8), .NUM_CS(3), .DIV_W(8)) dut (
    .clock(clock), .reset(reset), .start(start), .cs_sel(cs_sel), .cpol(cpol), .cpha(cpha),
    .clk_div(clk_div), .tx_data(tx_data), .busy(busy), .done(done), .err(err),
    .rx_data(rx_data), .sclk(sclk), .mosi(mosi), .miso(miso), .nss(nss)
  );

  always #5 clock = ~clock;
  assign miso = slave_en ? slave_bit : mosi;
  // mode-3 slave: drive on leading (falling) edge, capture MOSI on trailing (rising) edge
  always @(negedge sclk) if (slave_en) begin slave_bit = s_sr[7]; s_sr = s_sr << 1; end
  always @(posedge sclk) if (slave_en) mosi_seen = {mosi_seen[6:0], mosi};
  always @(negedge clock) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    spi_mode_t  mode;
    logic [7:0] dv, tx;
    logic [1:0] cs;
    logic       slv;
    logic [7:0] sw;
    int         poke;
    logic [7:0] erx;
    int         edone;
    logic [2:0] enss;
  } vec_t;
  vec_t v[5];

  task automatic xfer(input vec_t t, output int dcyc, output logic [2:0] nss1, output int nlow,
                      output logic sclk1, output logic sclk_end, output int rmin, output int rmax,
                      output logic busy_after);
    logic prev;
    int lastc;
    @(negedge clock);
    start = 1; cpol = t.mode.cpol; cpha = t.mode.cpha; clk_div = t.dv; tx_data = t.tx; cs_sel = t.cs;
    @(posedge clock); #1 start = 0;
    dcyc = -1; nlow = 0; rmin = 1000; rmax = 0; lastc = 0; prev = 0; nss1 = 0; sclk1 = 0; sclk_end = 0;
    for (int c = 1; c <= 2000 && dcyc < 0; c++) begin
      @(negedge clock);
      if (t.poke != 0 && c == t.poke) start = 1;
      if (t.poke != 0 && c == t.poke + 1) start = 0;
      if (c == 1) begin nss1 = nss; sclk1 = sclk; prev = sclk; end
      else if (sclk != prev) begin
        if (lastc > 0) begin
          if (c - lastc < rmin) rmin = c - lastc;
          if (c - lastc > rmax) rmax = c - lastc;
        end
        lastc = c; prev = sclk;
      end
      if (nss != 3'b111) nlow++;
      if (done) begin dcyc = c; sclk_end = sclk; end
    end
    start = 0;
    @(negedge clock);
    @(negedge clock);
    busy_after = busy;
  endtask

  initial begin
    int dcyc, nlow, rmin, rmax, d0, e0;
    logic [2:0] nss1;
    logic sclk1, sclk_end, busy_after;
    v[0] = '{SPI_MODE0, 8'd0, 8'hA5, 2'd0, 1'b0, 8'h00, 0, 8'hA5, 19, 3'b110};
    v[1] = '{SPI_MODE3, 8'd1, 8'h81, 2'd1, 1'b1, 8'h3C, 0, 8'h3C, 37, 3'b101};
    v[2] = '{SPI_MODE1, 8'd3, 8'h5A, 2'd2, 1'b0, 8'h00, 0, 8'h5A, 73, 3'b011};
    v[3] = '{SPI_MODE2, 8'd2, 8'hC3, 2'd0, 1'b0, 8'h00, 5, 8'hC3, 55, 3'b110};
    v[4] = '{SPI_MODE0, 8'd0, 8'h3C, 2'd1, 1'b0, 8'h00, 5, 8'h3C, 19, 3'b101};

    repeat (3) @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_nss", nss, 3'b111);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rx", rx_data, 0);

    for (int i = 0; i < 5; i++) begin
      slave_en = v[i].slv; s_sr = v[i].sw; slave_bit = 0; mosi_seen = 0;
      d0 = done_cnt;
      xfer(v[i], dcyc, nss1, nlow, sclk1, sclk_end, rmin, rmax, busy_after);
      slave_en = 0;
      chk($sformatf("v%0d_done_cycle", i), dcyc, v[i].edone);
      chk($sformatf("v%0d_rx", i), rx_data, v[i].erx);
      chk($sformatf("v%0d_nss_c1", i), nss1, v[i].enss);
      chk($sformatf("v%0d_nss_low", i), nlow, v[i].edone - 1);
      chk($sformatf("v%0d_sclk_c1", i), sclk1, v[i].mode.cpol);
      chk($sformatf("v%0d_sclk_end", i), sclk_end, v[i].mode.cpol);
      chk($sformatf("v%0d_run_min", i), rmin, v[i].dv + 1);
      chk($sformatf("v%0d_run_max", i), rmax, v[i].dv + 1);
      chk($sformatf("v%0d_done_count", i), done_cnt - d0, 1);
      chk($sformatf("v%0d_idle_after", i), busy_after, 0);
      if (v[i].slv) chk($sformatf("v%0d_mosi_bits", i), mosi_seen, v[i].tx);
    end
    chk("no_err_in_table", err_cnt, 0);

    // out-of-range chip select is rejected with a one-cycle err
    e0 = err_cnt;
    @(negedge clock);
    start = 1; cs_sel = 2'd3; cpol = 0; cpha = 0; clk_div = 0; tx_data = 8'hFF;
    @(posedge clock); #1 start = 0;
    @(negedge clock);
    chk("bad_cs_err", err, 1);
    chk("bad_cs_nss", nss, 3'b111);
    chk("bad_cs_busy", busy, 0);
    @(negedge clock);
    chk("bad_cs_err_pulse", err, 0);
    chk("bad_cs_busy2", busy, 0);
    chk("bad_cs_err_count", err_cnt - e0, 1);

    // reset in the middle of a transfer
    d0 = done_cnt;
    @(negedge clock);
    start = 1; cs_sel = 2'd0; cpol = 1; cpha = 0; clk_div = 0; tx_data = 8'h96;
    @(posedge clock); #1 start = 0;
    for (int c = 1; c <= 8; c++) @(negedge clock);
    chk("mid_busy_before", busy, 1);
    reset = 1;
    @(negedge clock);
    chk("mid_rst_nss", nss, 3'b111);
    chk("mid_rst_sclk", sclk, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rx", rx_data, 0);
    chk("mid_rst_done", done, 0);
    reset = 0;
    repeat (25) @(negedge clock);
    chk("mid_rst_no_done", done_cnt - d0, 0);
    chk("mid_rst_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
